// File: rtl/thermo_decode_pipe_if.sv
// Stream bundle for thermo_decode_pipe: thermometer words in, decoded level out.
// The slave modport is the decoder's view; the master modport is the producer/consumer side.
interface thermo_decode_pipe_if #(
  parameter int N  = 15,
  parameter int BW = $clog2(N + 1)
);
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  thermo_i;
  logic          out_valid;
  logic          out_ready;
  logic [N:0]    onehot_o;
  logic [BW-1:0] bin_o;
  logic          bubble_o;

  modport master (
    output in_valid, thermo_i, out_ready,
    input  in_ready, out_valid, onehot_o, bin_o, bubble_o
  );

  modport slave (
    input  in_valid, thermo_i, out_ready,
    output in_ready, out_valid, onehot_o, bin_o, bubble_o
  );
endinterface

// File: rtl/thermo_decode_pipe.sv
// Two-stage thermometer-to-one-hot/binary decoder with bubble flag and saturating bubble counter.
// Define THERMO_BUBBLE_FIX_EN to majority-filter single-bit bubbles before decode.
module thermo_decode_pipe #(
  parameter int N     = 15,
  parameter int BW    = $clog2(N + 1),
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  thermo_decode_pipe_if.slave  bus,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     bubble_cnt_o
);

  logic          s1_valid;
  logic          s2_valid;
  logic          s2_load;
  logic          in_fire;
  logic [N-1:0]  cond;
  logic [N-1:0]  s1_therm;
  logic          raw_bubble;
  logic          s1_bubble;
  logic [N+1:0]  dec_ext;
  logic [N:0]    onehot_nxt;
  logic [N:0]    onehot_q;
  logic [BW-1:0] bin_nxt;
  logic [BW-1:0] bin_q;
  logic          bubble_q;

  assign s2_load      = ~s2_valid | bus.out_ready;
  assign bus.in_ready = ~s1_valid | s2_load;
  assign in_fire      = bus.in_valid & bus.in_ready;

  // A 0 directly below a 1 anywhere in the word marks a non-monotonic sample.
  assign raw_bubble = |(~bus.thermo_i[N-2:0] & bus.thermo_i[N-1:1]);

`ifdef THERMO_BUBBLE_FIX_EN
  logic [N+1:0] in_ext;

  assign in_ext = {1'b0, bus.thermo_i, 1'b1};

  always_comb begin
    cond = '0;
    for (int i = 0; i < N; i++) begin
      cond[i] = (in_ext[i] & in_ext[i+1]) |
                (in_ext[i] & in_ext[i+2]) |
                (in_ext[i+1] & in_ext[i+2]);
    end
  end
`else
  assign cond = bus.thermo_i;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_therm  <= '0;
      s1_bubble <= 1'b0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_therm  <= cond;
        s1_bubble <= raw_bubble;
      end
    end
  end

  // Later transitions overwrite earlier ones, so the highest 1->0 edge wins.
  assign dec_ext = {1'b0, s1_therm, 1'b1};

  always_comb begin
    onehot_nxt = {{N{1'b0}}, 1'b1};
    bin_nxt    = '0;
    for (int k = 0; k <= N; k++) begin
      if (dec_ext[k] & ~dec_ext[k+1]) begin
        onehot_nxt    = '0;
        onehot_nxt[k] = 1'b1;
        bin_nxt       = BW'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      onehot_q <= {{N{1'b0}}, 1'b1};
      bin_q    <= '0;
      bubble_q <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        onehot_q <= onehot_nxt;
        bin_q    <= bin_nxt;
        bubble_q <= s1_bubble;
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.onehot_o  = onehot_q;
  assign bus.bin_o     = bin_q;
  assign bus.bubble_o  = bubble_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_cnt_o <= '0;
    end else if (cnt_clr) begin
      bubble_cnt_o <= '0;
    end else if (in_fire && raw_bubble && (bubble_cnt_o != {CNT_W{1'b1}})) begin
      bubble_cnt_o <= bubble_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_thermo_decode_pipe.sv
// Self-checking bench for thermo_decode_pipe: a 15-bit/8-bit-counter instance and a 7-bit/2-bit-counter instance
// checked against a level/bubble reference model derived from the code's meaning.
module tb_thermo_decode_pipe;

  localparam int NA  = 15;
  localparam int NB  = 7;
  localparam int CWA = 8;
  localparam int CWB = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           clr_a = 1'b0;
  logic           clr_b = 1'b0;
  logic [CWA-1:0] cnt_a;
  logic [CWB-1:0] cnt_b;

  thermo_decode_pipe_if #(.N(NA)) bus_a ();
  thermo_decode_pipe_if #(.N(NB)) bus_b ();

  thermo_decode_pipe #(.N(NA), .CNT_W(CWA)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .cnt_clr(clr_a), .bubble_cnt_o(cnt_a)
  );

  thermo_decode_pipe #(.N(NB), .CNT_W(CWB)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .cnt_clr(clr_b), .bubble_cnt_o(cnt_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int qa_k[$];
  bit qa_b[$];
  int qb_k[$];
  bit qb_b[$];
  int exp_cnt_a = 0;
  int exp_cnt_b = 0;
  bit last_in_ready;
  bit stall_prev = 1'b0;
  logic [63:0] prev_bin;
  logic [63:0] prev_onehot;

  // Level = number of ones the (optionally majority-filtered) code claims, i.e. top set bit + 1.
  function automatic int ref_level(input logic [63:0] t, input int n);
    logic [63:0] c;
    int k;
    c = t;
`ifdef THERMO_BUBBLE_FIX_EN
    for (int i = 0; i < n; i++) begin
      int lo;
      int hi;
      lo = (i == 0) ? 1 : int'(t[i-1]);
      hi = (i == n - 1) ? 0 : int'(t[i+1]);
      c[i] = ((lo + int'(t[i]) + hi) >= 2);
    end
`endif
    k = 0;
    for (int i = 0; i < n; i++) if (c[i]) k = i + 1;
    return k;
  endfunction

  // A legal code is 2^m-1; anything else contains a bubble.
  function automatic bit ref_bubble(input logic [63:0] t, input int n);
    logic [63:0] m;
    m = t & ((64'd1 << n) - 64'd1);
    return (m & (m + 64'd1)) != 64'd0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic checkOutput(input bit inst);
    int k;
    bit b;
    if (inst == 1'b0) begin
      if (qa_k.size() == 0) begin
        check("a_spurious_out", 64'(bus_a.out_valid), 64'd0);
      end else begin
        k = qa_k.pop_front();
        b = qa_b.pop_front();
        check("a_bin", 64'(bus_a.bin_o), 64'(k));
        check("a_onehot", 64'(bus_a.onehot_o), 64'd1 << k);
        check("a_bubble", 64'(bus_a.bubble_o), 64'(b));
      end
    end else begin
      if (qb_k.size() == 0) begin
        check("b_spurious_out", 64'(bus_b.out_valid), 64'd0);
      end else begin
        k = qb_k.pop_front();
        b = qb_b.pop_front();
        check("b_bin", 64'(bus_b.bin_o), 64'(k));
        check("b_onehot", 64'(bus_b.onehot_o), 64'd1 << k);
        check("b_bubble", 64'(bus_b.bubble_o), 64'(b));
      end
    end
  endtask

  task automatic flushModel();
    qa_k.delete(); qa_b.delete();
    qb_k.delete(); qb_b.delete();
    exp_cnt_a = 0;
    exp_cnt_b = 0;
    stall_prev = 1'b0;
  endtask

  // One clock of stimulus on instance A; ends 1 time unit after the rising edge.
  task automatic applyStimulus(input bit v, input logic [NA-1:0] d, input bit ordy, input bit clr);
    bit in_x;
    bit out_x;
    bus_a.in_valid  = v;
    bus_a.thermo_i  = d;
    bus_a.out_ready = ordy;
    clr_a           = clr;
    @(negedge clk);
    if (rst_n && stall_prev) begin
      check("a_hold_bin", 64'(bus_a.bin_o), prev_bin);
      check("a_hold_onehot", 64'(bus_a.onehot_o), prev_onehot);
    end
    last_in_ready = bus_a.in_ready;
    in_x  = rst_n && bus_a.in_valid && bus_a.in_ready;
    out_x = rst_n && bus_a.out_valid && bus_a.out_ready;
    stall_prev  = rst_n && bus_a.out_valid && !bus_a.out_ready;
    prev_bin    = 64'(bus_a.bin_o);
    prev_onehot = 64'(bus_a.onehot_o);
    if (out_x) checkOutput(1'b0);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      flushModel();
    end else begin
      if (in_x) begin
        qa_k.push_back(ref_level(64'(d), NA));
        qa_b.push_back(ref_bubble(64'(d), NA));
      end
      if (clr) exp_cnt_a = 0;
      else if (in_x && ref_bubble(64'(d), NA) && exp_cnt_a < (1 << CWA) - 1) exp_cnt_a++;
    end
    check("a_bubble_cnt", 64'(cnt_a), 64'(exp_cnt_a));
  endtask

  // One clock of stimulus on instance B with the consumer always ready.
  task automatic stepB(input bit v, input logic [NB-1:0] d, input bit clr);
    bit in_x;
    bit out_x;
    bus_b.in_valid  = v;
    bus_b.thermo_i  = d;
    bus_b.out_ready = 1'b1;
    clr_b           = clr;
    @(negedge clk);
    in_x  = rst_n && bus_b.in_valid && bus_b.in_ready;
    out_x = rst_n && bus_b.out_valid && bus_b.out_ready;
    if (out_x) checkOutput(1'b1);
    @(posedge clk);
    #1;
    if (in_x) begin
      qb_k.push_back(ref_level(64'(d), NB));
      qb_b.push_back(ref_bubble(64'(d), NB));
    end
    if (clr) exp_cnt_b = 0;
    else if (in_x && ref_bubble(64'(d), NB) && exp_cnt_b < (1 << CWB) - 1) exp_cnt_b++;
    check("b_bubble_cnt", 64'(cnt_b), 64'(exp_cnt_b));
  endtask

  task automatic drainA(input string tag);
    int guard;
    guard = 0;
    while (qa_k.size() != 0 && guard < 20) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      guard++;
    end
    check(tag, 64'(qa_k.size()), 64'd0);
  endtask

  initial begin
    logic [NA-1:0] d;
    int expect_17;

    bus_a.in_valid = 1'b0; bus_a.thermo_i = '0; bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.thermo_i = '0; bus_b.out_ready = 1'b1;

    rst_n = 1'b0;
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    rst_n = 1'b1;
    check("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    check("rst_onehot", 64'(bus_a.onehot_o), 64'd1);
    check("rst_bin", 64'(bus_a.bin_o), 64'd0);
    check("rst_bubble", 64'(bus_a.bubble_o), 64'd0);
    check("rst_cnt", 64'(cnt_a), 64'd0);

    // Legal-code sweep, back-to-back, with latency probes on the first two cycles.
    for (int k = 0; k <= NA; k++) begin
      d = NA'((32'd1 << k) - 32'd1);
      applyStimulus(1'b1, d, 1'b1, 1'b0);
      if (k == 0) begin
        check("sweep_in_ready", 64'(last_in_ready), 64'd1);
        check("lat_cycle1_valid", 64'(bus_a.out_valid), 64'd0);
      end
      if (k == 1) check("lat_cycle2_valid", 64'(bus_a.out_valid), 64'd1);
    end
    drainA("sweep_drain");

    // Stalled consumer: only two samples fit, then in_ready drops.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, NA'((32'd1 << (i + 3)) - 32'd1), 1'b0, 1'b0);
      check($sformatf("bp_in_ready_%0d", i), 64'(last_in_ready), (i < 2) ? 64'd1 : 64'd0);
    end
    check("bp_accepted", 64'(qa_k.size()), 64'd2);
    drainA("bp_drain");

    // Directed bubble words; bit 3 of 0x17 is refilled by majority(1,0,1) when filtering.
`ifdef THERMO_BUBBLE_FIX_EN
    expect_17 = 4;
`else
    expect_17 = 5;
`endif
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    applyStimulus(1'b1, 15'h0017, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    check("bub17_bin", 64'(bus_a.bin_o), 64'(expect_17));
    check("bub17_flag", 64'(bus_a.bubble_o), 64'd1);
    check("bub17_cnt", 64'(cnt_a), 64'd1);
    drainA("bub17_drain");
    applyStimulus(1'b1, 15'h005F, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    check("bub5f_bin", 64'(bus_a.bin_o), 64'd7);
    check("bub5f_flag", 64'(bus_a.bubble_o), 64'd1);
    drainA("bub5f_drain");

    // Randomized traffic with random backpressure and occasional clears.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 0) d = NA'((32'd1 << $urandom_range(0, NA)) - 32'd1);
      else d = NA'($urandom);
      applyStimulus($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end
    drainA("rand_drain");

    // Narrow instance: full-scale and zero codes, then counter saturation and clear priority.
    stepB(1'b1, 7'h7F, 1'b0);
    stepB(1'b1, 7'h00, 1'b0);
    check("b_full_bin", 64'(bus_b.bin_o), 64'd7);
    check("b_full_onehot", 64'(bus_b.onehot_o), 64'h80);
    stepB(1'b0, '0, 1'b0);
    check("b_zero_bin", 64'(bus_b.bin_o), 64'd0);
    for (int i = 0; i < 5; i++) stepB(1'b1, 7'h05, 1'b0);
    check("b_cnt_saturated", 64'(cnt_b), 64'd3);
    stepB(1'b1, 7'h05, 1'b1);
    check("b_cnt_clear_wins", 64'(cnt_b), 64'd0);
    for (int i = 0; i < 4; i++) stepB(1'b0, '0, 1'b0);
    check("b_drain", 64'(qb_k.size()), 64'd0);

    // Reset with both stages occupied.
    applyStimulus(1'b1, 15'h0003, 1'b0, 1'b0);
    applyStimulus(1'b1, 15'h00FF, 1'b0, 1'b0);
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    check("mid_rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    check("mid_rst_onehot", 64'(bus_a.onehot_o), 64'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      check("post_rst_in_ready", 64'(last_in_ready), 64'd1);
      check("post_rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
